// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction width, NOP encoding, sequencer state
// encoding and the instruction field positions that the decoder also uses.
package tpu_pkg;

    localparam int INSTR_W = 25;

    // All-zero word: no load, no switch, no start.
    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

    // Instruction field bit positions (shared with the decoder).
    localparam int LR_IS_BACKWARD_BIT = 24;
    localparam int CTRL_MSB           = 23;
    localparam int CTRL_LSB           = 16;
    localparam int DATA_IN_MSB        = 15;
    localparam int DATA_IN_LSB        = 0;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program buffer: DEPTH x INSTR_W register file with one synchronous write
// port and one asynchronous read port. The reader registers the output.
module instr_mem #(
    parameter int DEPTH   = 64,
    parameter int INSTR_W = tpu_pkg::INSTR_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INSTR_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INSTR_W-1:0]       rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; stale words are unreachable until reloaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program buffer and sequencer feeding the instruction decoder.
// Loads a program over a valid/ready stream, then replays it one word per
// cycle on start, holding the PC and issuing NOPs while stalled.
// Optional feature macro: INSTR_SEQ_REPEAT_EN (adds repeat_cnt, replays the
// program repeat_cnt+1 times back-to-back).
module instr_sequencer #(
    parameter int DEPTH   = 64,
    parameter int INSTR_W = tpu_pkg::INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prog_valid,
    output logic                     prog_ready,
    input  logic [INSTR_W-1:0]       prog_data,
    input  logic                     prog_last,
    input  logic                     start,
`ifdef INSTR_SEQ_REPEAT_EN
    input  logic [7:0]               repeat_cnt,
`endif
    input  logic                     stall,
    output logic [INSTR_W-1:0]       instruction,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done
);

    import tpu_pkg::*;

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

    seq_state_t         state,  state_nxt;
    logic [AW:0]        count,  count_nxt;
    logic [AW:0]        len,    len_nxt;
    logic [AW-1:0]      rd_ptr, rd_ptr_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic               valid_nxt;
    logic [AW-1:0]      pc_nxt;
    logic               done_nxt;
    logic               mem_we;
    logic [INSTR_W-1:0] rd_data;
    logic               last_word;
`ifdef INSTR_SEQ_REPEAT_EN
    logic [7:0]         passes_left, passes_left_nxt;
`endif

    instr_mem #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (count[AW-1:0]),
        .wdata (prog_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Ready depends only on state and fill level, never on prog_valid.
    assign prog_ready = (state == LOAD) && (count < DEPTH_C);
    assign busy       = (state == RUN);
    assign last_word  = ({1'b0, rd_ptr} == (len - ONE_C));

    // Next-state, buffer write and issue decisions.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        len_nxt    = len;
        rd_ptr_nxt = rd_ptr;
        instr_nxt  = INSTR_W'(INSTR_NOP);
        valid_nxt  = 1'b0;
        pc_nxt     = pc;
        done_nxt   = 1'b0;
        mem_we     = 1'b0;
`ifdef INSTR_SEQ_REPEAT_EN
        passes_left_nxt = passes_left;
`endif
        case (state)
            LOAD: begin
                if (prog_valid && prog_ready) begin
                    mem_we    = 1'b1;
                    count_nxt = count + ONE_C;
                    if (prog_last || (count == (DEPTH_C - ONE_C))) begin
                        len_nxt   = count + ONE_C;
                        state_nxt = READY;
                    end
                end
            end
            READY: begin
                if (start) begin
                    state_nxt  = RUN;
                    rd_ptr_nxt = '0;
`ifdef INSTR_SEQ_REPEAT_EN
                    passes_left_nxt = repeat_cnt;
`endif
                end
            end
            RUN: begin
                if (!stall) begin
                    instr_nxt  = rd_data;
                    valid_nxt  = 1'b1;
                    pc_nxt     = rd_ptr;
                    rd_ptr_nxt = rd_ptr + 1'b1;
                    if (last_word) begin
`ifdef INSTR_SEQ_REPEAT_EN
                        if (passes_left != 8'd0) begin
                            passes_left_nxt = passes_left - 8'd1;
                            rd_ptr_nxt      = '0;
                        end else begin
                            state_nxt = DONE;
                        end
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                count_nxt = '0;
                state_nxt = LOAD;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // State and registered outputs; async active-low reset clears everything but the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            count       <= '0;
            len         <= '0;
            rd_ptr      <= '0;
            instruction <= INSTR_W'(INSTR_NOP);
            instr_valid <= 1'b0;
            pc          <= '0;
            done        <= 1'b0;
`ifdef INSTR_SEQ_REPEAT_EN
            passes_left <= '0;
`endif
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            len         <= len_nxt;
            rd_ptr      <= rd_ptr_nxt;
            instruction <= instr_nxt;
            instr_valid <= valid_nxt;
            pc          <= pc_nxt;
            done        <= done_nxt;
`ifdef INSTR_SEQ_REPEAT_EN
            passes_left <= passes_left_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Expected issue streams are built
// from the program list (repeated per pass) and consumed one word per
// non-stalled cycle. Define INSTR_SEQ_REPEAT_EN to also exercise repeats.
module tb_instr_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int W     = tpu_pkg::INSTR_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_valid;
    logic          prog_ready;
    logic [W-1:0]  prog_data;
    logic          prog_last;
    logic          start;
    logic          stall;
    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
`ifdef INSTR_SEQ_REPEAT_EN
    logic [7:0]    repeat_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] prog_q[$];

    instr_sequencer #(
        .DEPTH   (DEPTH),
        .INSTR_W (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_data   (prog_data),
        .prog_last   (prog_last),
        .start       (start),
`ifdef INSTR_SEQ_REPEAT_EN
        .repeat_cnt  (repeat_cnt),
`endif
        .stall       (stall),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push the program in prog_q through the load stream.
    task automatic load_program(input bit use_last, input bit gaps);
        int n;
        n = prog_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(3) == 0; g++) begin
                    prog_valid = 1'b0;
                    step();
                end
            end
            prog_valid = 1'b1;
            prog_data  = prog_q[i];
            prog_last  = use_last && (i == n - 1);
            checks++;
            if (prog_ready !== 1'b1)
                $display("[TB] FAIL load_ready word %0d: got %b expected 1", i, prog_ready);
            if (prog_ready !== 1'b1) errors++;
            step();
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        checks++;
        if (prog_ready !== 1'b0) begin
            $display("[TB] FAIL ready_after_load: got %b expected 0", prog_ready);
            errors++;
        end
    endtask

    // Start the loaded program and check every issued cycle against the model.
    task automatic run_program(input int reps, input bit rand_stall,
                               input logic [63:0] stall_pat, input bit noise);
        logic [W-1:0] exp_q[$];
        int           exp_pc[$];
        int           n, k, cyc, limit;
        bit           s;
        n = prog_q.size();
        for (int r = 0; r <= reps; r++)
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(prog_q[i]);
                exp_pc.push_back(i);
            end
`ifdef INSTR_SEQ_REPEAT_EN
        repeat_cnt = reps[7:0];
`endif
        if (noise) begin
            prog_valid = 1'b1;
            prog_last  = 1'b1;
            prog_data  = W'($urandom);
            step();
            prog_valid = 1'b0;
            prog_last  = 1'b0;
            checks++;
            if (busy !== 1'b0 || prog_ready !== 1'b0) begin
                $display("[TB] FAIL ready_ignores_prog: busy=%b ready=%b expected 0/0", busy, prog_ready);
                errors++;
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            $display("[TB] FAIL busy_after_start: got %b expected 1", busy);
            errors++;
        end
        k     = 0;
        cyc   = 0;
        limit = 4 * exp_q.size() + 64;
        while (k < exp_q.size() && cyc < limit) begin
            s = rand_stall ? ($urandom_range(3) == 0) : ((cyc < 64) ? stall_pat[cyc] : 1'b0);
            stall = s;
            if (noise) begin
                start      = 1'($urandom_range(1));
                prog_valid = 1'($urandom_range(1));
                prog_last  = 1'b1;
                prog_data  = W'($urandom);
            end
            step();
            if (s) begin
                checks++;
                if (instruction !== '0 || instr_valid !== 1'b0) begin
                    $display("[TB] FAIL stall_nop cyc %0d: instr=%h valid=%b expected 0/0", cyc, instruction, instr_valid);
                    errors++;
                end
            end else begin
                checks++;
                if (instruction !== exp_q[k] || instr_valid !== 1'b1) begin
                    $display("[TB] FAIL issue word %0d: instr=%h valid=%b expected %h/1", k, instruction, instr_valid, exp_q[k]);
                    errors++;
                end
                checks++;
                if (pc !== AW'(exp_pc[k])) begin
                    $display("[TB] FAIL pc word %0d: got %0d expected %0d", k, pc, exp_pc[k]);
                    errors++;
                end
                k++;
            end
            checks++;
            if (busy !== (k < exp_q.size())) begin
                $display("[TB] FAIL busy cyc %0d: got %b expected %b", cyc, busy, (k < exp_q.size()));
                errors++;
            end
            cyc++;
        end
        if (k < exp_q.size()) begin
            $display("[TB] FAIL run_timeout: issued %0d expected %0d", k, exp_q.size());
            errors++;
        end
        stall = 1'b0; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
        step();
        checks++;
        if (done !== 1'b1 || instruction !== '0 || instr_valid !== 1'b0 || busy !== 1'b0 || prog_ready !== 1'b1) begin
            $display("[TB] FAIL done_cycle: done=%b instr=%h valid=%b busy=%b ready=%b expected 1/0/0/0/1",
                     done, instruction, instr_valid, busy, prog_ready);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b0 || instr_valid !== 1'b0) begin
            $display("[TB] FAIL done_single: done=%b valid=%b expected 0/0", done, instr_valid);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
        start = 1'b0; stall = 1'b0;
`ifdef INSTR_SEQ_REPEAT_EN
        repeat_cnt = '0;
`endif
        repeat (3) step();
        checks++;
        if (instruction !== '0 || instr_valid !== 1'b0 || pc !== '0 || busy !== 1'b0 || done !== 1'b0 || prog_ready !== 1'b1) begin
            $display("[TB] FAIL reset_values: instr=%h valid=%b pc=%0d busy=%b done=%b ready=%b expected 0/0/0/0/0/1",
                     instruction, instr_valid, pc, busy, done, prog_ready);
            errors++;
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        prog_q = '{25'h0100001, 25'h0440002, 25'h1800003};
        load_program(1'b1, 1'b0);
        run_program(0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic test_stall();
        prog_q = '{25'h0100001, 25'h0440002, 25'h1800003};
        load_program(1'b1, 1'b0);
        run_program(0, 1'b0, 64'b110, 1'b0);
    endtask

    task automatic test_fill();
        prog_q.delete();
        for (int i = 0; i < DEPTH; i++) prog_q.push_back(W'($urandom));
        load_program(1'b0, 1'b1);
        run_program(0, 1'b1, 64'd0, 1'b0);
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            checks++;
            if (busy !== 1'b0 || instr_valid !== 1'b0 || prog_ready !== 1'b1) begin
                $display("[TB] FAIL start_in_load: busy=%b valid=%b ready=%b expected 0/0/1", busy, instr_valid, prog_ready);
                errors++;
            end
        end
        prog_q.delete();
        for (int i = 0; i < 7; i++) prog_q.push_back(W'($urandom));
        load_program(1'b1, 1'b0);
        run_program(0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            n = (t == 0) ? 1 : int'($urandom_range(DEPTH, 1));
            prog_q.delete();
            for (int i = 0; i < n; i++) prog_q.push_back(W'($urandom));
            load_program(1'b1, 1'b1);
            run_program(0, 1'b1, 64'd0, (t % 2) == 1);
        end
    endtask

    task automatic test_reset_mid_run();
        prog_q.delete();
        for (int i = 0; i < 5; i++) prog_q.push_back(W'($urandom));
        load_program(1'b1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (instruction !== '0 || instr_valid !== 1'b0 || busy !== 1'b0 || pc !== '0 || prog_ready !== 1'b1) begin
            $display("[TB] FAIL reset_async: instr=%h valid=%b busy=%b pc=%0d ready=%b expected 0/0/0/0/1",
                     instruction, instr_valid, busy, pc, prog_ready);
            errors++;
        end
        step();
        checks++;
        if (instruction !== '0 || busy !== 1'b0 || pc !== '0 || prog_ready !== 1'b1) begin
            $display("[TB] FAIL reset_mid_run: instr=%h busy=%b pc=%0d ready=%b expected 0/0/0/1",
                     instruction, busy, pc, prog_ready);
            errors++;
        end
        #2 rst_n = 1'b1;
        step();
        prog_q = '{25'h0123456, 25'h1ABCDEF};
        load_program(1'b1, 1'b0);
        run_program(0, 1'b0, 64'd0, 1'b0);
    endtask

`ifdef INSTR_SEQ_REPEAT_EN
    task automatic test_repeat();
        prog_q = '{25'h00000AA, 25'h00000BB};
        load_program(1'b1, 1'b0);
        run_program(2, 1'b0, 64'd0, 1'b0);
        prog_q.delete();
        for (int i = 0; i < 5; i++) prog_q.push_back(W'($urandom));
        load_program(1'b1, 1'b0);
        run_program(int'($urandom_range(4, 1)), 1'b1, 64'd0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_fill();
        test_start_ignored();
        test_random();
        test_reset_mid_run();
`ifdef INSTR_SEQ_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
